// File: rtl/spi_slave_ram_if.sv
// Serial and sensor-side signals of the SPI register file, grouped for the slave
// port and for the bench/front-end side that drives them.
interface spi_slave_ram_if;
    logic        csb;
    logic        mosi;
    logic        miso;
    logic        ldb;
    logic [10:0] sensor_data [16];

    modport slave (
        input  csb,
        input  mosi,
        input  ldb,
        input  sensor_data,
        output miso
    );

    modport master (
        output csb,
        output mosi,
        output ldb,
        output sensor_data,
        input  miso
    );
endinterface

// File: rtl/spi_slave_ram.sv
// SPI slave register file: sixteen 11-bit words, 16-bit MSB-first read/write
// frames, plus an active-low strobe that snapshots all sensor words at once.
module spi_slave_ram (
    input  logic             spi_clk,
    input  logic             rst,
    spi_slave_ram_if.slave   bus
);
    logic [4:0]  r_cnt;
    logic [9:0]  r_shift;
    logic [9:0]  r_rd_shift;
    logic        r_rw;
    logic [3:0]  r_addr;
    logic        r_miso;
    logic [10:0] r_mem [16];

    logic [4:0]  w_cnt_nxt;
    logic [9:0]  w_shift_nxt;
    logic [9:0]  w_rd_shift_nxt;
    logic        w_rw_nxt;
    logic [3:0]  w_addr_nxt;
    logic        w_miso_nxt;
    logic [3:0]  w_cap_addr;
    logic        w_commit;

    // The first four sampled bits sit in r_shift[3:0] = {rw, a3, a2, a1}
    assign w_cap_addr = {r_shift[2:0], bus.mosi};
    assign w_commit   = ~bus.csb && (r_cnt == 5'd15) && ~r_rw;
    assign bus.miso   = r_miso;

    // Next-state for the frame counter, shifters, captured header and miso
    always_comb begin
        w_cnt_nxt      = r_cnt;
        w_shift_nxt    = r_shift;
        w_rd_shift_nxt = r_rd_shift;
        w_rw_nxt       = r_rw;
        w_addr_nxt     = r_addr;
        w_miso_nxt     = 1'b0;
        if (bus.csb) begin
            w_cnt_nxt      = 5'd0;
            w_shift_nxt    = 10'd0;
            w_rd_shift_nxt = 10'd0;
            w_rw_nxt       = 1'b0;
            w_miso_nxt     = 1'b0;
        end else if (r_cnt != 5'd16) begin
            w_cnt_nxt   = r_cnt + 5'd1;
            w_shift_nxt = {r_shift[8:0], bus.mosi};
            if (r_cnt == 5'd4) begin
                w_rw_nxt   = r_shift[3];
                w_addr_nxt = w_cap_addr;
                if (r_shift[3]) begin
                    w_miso_nxt     = r_mem[w_cap_addr][10];
                    w_rd_shift_nxt = r_mem[w_cap_addr][9:0];
                end else begin
                    w_miso_nxt     = 1'b0;
                    w_rd_shift_nxt = 10'd0;
                end
            end else if ((r_cnt >= 5'd5) && (r_cnt <= 5'd14)) begin
                // Write frames leave the read shifter at zero, so miso stays low
                w_miso_nxt     = r_rd_shift[9];
                w_rd_shift_nxt = {r_rd_shift[8:0], 1'b0};
            end else begin
                w_miso_nxt = 1'b0;
            end
        end else begin
            w_miso_nxt = 1'b0;
        end
    end

    // Frame-state registers
    always_ff @(posedge spi_clk) begin
        if (rst) begin
            r_cnt      <= 5'd0;
            r_shift    <= 10'd0;
            r_rd_shift <= 10'd0;
            r_rw       <= 1'b0;
            r_addr     <= 4'd0;
            r_miso     <= 1'b0;
        end else begin
            r_cnt      <= w_cnt_nxt;
            r_shift    <= w_shift_nxt;
            r_rd_shift <= w_rd_shift_nxt;
            r_rw       <= w_rw_nxt;
            r_addr     <= w_addr_nxt;
            r_miso     <= w_miso_nxt;
        end
    end

    // Register file: a sensor load overrides a same-edge write commit
    always_ff @(posedge spi_clk) begin
        if (rst) begin
            for (int i = 0; i < 16; i++) begin
                r_mem[i] <= 11'd0;
            end
        end else if (~bus.ldb) begin
            for (int i = 0; i < 16; i++) begin
                r_mem[i] <= bus.sensor_data[i];
            end
        end else if (w_commit) begin
            r_mem[r_addr] <= {r_shift[9:0], bus.mosi};
        end else begin
            r_mem[r_addr] <= r_mem[r_addr];
        end
    end
endmodule

// File: tb/tb_spi_slave_ram.sv
// Directed bench for spi_slave_ram: drives SPI frames MSB-first on the falling
// edge, samples miso just after the rising edge, compares with fixed values.
module tb_spi_slave_ram;
    logic spi_clk;
    logic rst;
    int   errors;
    int   checks;

    spi_slave_ram_if bus ();

    spi_slave_ram dut (
        .spi_clk (spi_clk),
        .rst     (rst),
        .bus     (bus.slave)
    );

    initial spi_clk = 1'b0;
    always #5 spi_clk = ~spi_clk;

    task automatic check(input string tag, input logic [10:0] obs, input logic [10:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One csb-low window of nbits; ldb held low during sample ldb_at (-1 = never).
    // Bits past the 16th are driven as 1 so any over-counting corrupts data.
    task automatic xfer(input logic [15:0] frm, input int nbits, input int ldb_at,
                        output logic [10:0] rd, output logic zero_ok);
        logic rw;
        rw = frm[15];
        rd = 11'd0;
        zero_ok = 1'b1;
        for (int i = 0; i < nbits; i++) begin
            @(negedge spi_clk);
            bus.csb  = 1'b0;
            bus.mosi = (i < 16) ? frm[15 - i] : 1'b1;
            bus.ldb  = (i == ldb_at) ? 1'b0 : 1'b1;
            @(posedge spi_clk);
            #1;
            if (rw && i >= 4 && i <= 14) begin
                rd[14 - i] = bus.miso;
            end else if (bus.miso !== 1'b0) begin
                zero_ok = 1'b0;
            end
        end
        @(negedge spi_clk);
        bus.csb  = 1'b1;
        bus.ldb  = 1'b1;
        bus.mosi = 1'b0;
        @(posedge spi_clk);
        #1;
        if (bus.miso !== 1'b0) zero_ok = 1'b0;
    endtask

    task automatic do_read(input logic [3:0] addr, input int nbits,
                           input logic [10:0] exp, input string tag);
        logic [10:0] rd;
        logic        zok;
        xfer({1'b1, addr, 11'h7FF}, nbits, -1, rd, zok);
        check({tag, "_data"}, rd, exp);
        check({tag, "_miso_idle"}, {10'd0, zok}, 11'd1);
    endtask

    task automatic do_write(input logic [3:0] addr, input logic [10:0] data,
                            input int nbits, input int ldb_at, input string tag);
        logic [10:0] rd;
        logic        zok;
        xfer({1'b0, addr, data}, nbits, ldb_at, rd, zok);
        check({tag, "_miso_low"}, {10'd0, zok}, 11'd1);
    endtask

    initial begin
        logic [15:0] frm;
        errors = 0;
        checks = 0;
        rst = 1'b1;
        bus.csb = 1'b1;
        bus.mosi = 1'b0;
        bus.ldb = 1'b1;
        for (int n = 0; n < 16; n++) bus.sensor_data[n] = 11'd0;
        bus.sensor_data[0]  = 11'h555;
        bus.sensor_data[1]  = 11'h3AA;
        bus.sensor_data[15] = 11'h1C3;
        repeat (3) @(negedge spi_clk);
        rst = 1'b0;
        check("reset_miso", {10'd0, bus.miso}, 11'd0);

        do_read(4'd3, 16, 11'h000, "rst_rd3");

        // Sensor load with csb low for one edge, then the window is abandoned
        @(negedge spi_clk);
        bus.csb = 1'b0;
        bus.ldb = 1'b0;
        @(negedge spi_clk);
        bus.csb = 1'b1;
        bus.ldb = 1'b1;
        do_read(4'd0, 16, 11'h555, "load_rd0");
        do_read(4'd1, 16, 11'h3AA, "load_rd1");

        do_write(4'd1, 11'h123, 16, -1, "wr1");
        do_read(4'd1, 16, 11'h123, "wr_rd1");
        do_read(4'd0, 16, 11'h555, "wr_rd0");

        do_write(4'd15, 11'h7FF, 10, -1, "abort_wr15");
        do_read(4'd15, 16, 11'h1C3, "abort_rd15");

        bus.sensor_data[2] = 11'h00A;
        do_write(4'd2, 11'h0F0, 16, 15, "coll_wr2");
        do_read(4'd2, 16, 11'h00A, "coll_rd2");
        do_read(4'd1, 16, 11'h3AA, "coll_rd1");

        do_write(4'd4, 11'h246, 20, -1, "long_wr4");
        do_read(4'd4, 16, 11'h246, "long_rd4");
        do_read(4'd4, 20, 11'h246, "long20_rd4");

        // Reset lands on the 16th-bit edge of a write: no commit, mem cleared
        frm = {1'b0, 4'd4, 11'h333};
        for (int i = 0; i < 15; i++) begin
            @(negedge spi_clk);
            bus.csb  = 1'b0;
            bus.mosi = frm[15 - i];
        end
        @(negedge spi_clk);
        bus.mosi = frm[0];
        rst = 1'b1;
        @(negedge spi_clk);
        rst = 1'b0;
        bus.csb = 1'b1;
        bus.mosi = 1'b0;
        check("midrst_miso", {10'd0, bus.miso}, 11'd0);
        do_read(4'd4, 16, 11'h000, "midrst_rd4");
        do_read(4'd0, 16, 11'h000, "midrst_rd0");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
